// File: rtl/res_dump_uart_pkg.sv
// Shared constants, state encodings and the hex-to-ASCII helper for the
// resource-dump UART monitor.
package res_dump_uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 434;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETADR  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SEND    = 3'd4,
        S_EOL     = 3'd5
    } dump_state_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'd0, nib};
        end else begin
            return ASCII_A + {4'd0, nib} - 8'd10;
        end
    endfunction

endpackage

// File: rtl/res_dump_uart_tx_byte.sv
// UART 8N1 byte transmitter with a valid/ready load port. The final stop-bit
// clock is spent in idle so a queued byte follows the stop bit with no gap.
module uart_tx_byte
    import res_dump_uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST      = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_STOP_LAST = CW'(BAUD_DIV - 2);

    tx_state_t     state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    bit_r, bit_s;
    logic [8:0]    shift_r, shift_s;
    logic          txd_r, txd_s;

    // Frame sequencing: start bit on load, then 8 data bits and the stop bit.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        txd_s   = txd_r;
        case (state_r)
            TX_IDLE: begin
                txd_s = 1'b1;
                if (valid) begin
                    state_s = TX_BUSY;
                    shift_s = {1'b1, data};
                    txd_s   = 1'b0;
                    cnt_s   = '0;
                    bit_s   = 4'd0;
                end else begin
                    state_s = TX_IDLE;
                end
            end
            TX_BUSY: begin
                if (bit_r == 4'd9 && cnt_r == CNT_STOP_LAST) begin
                    state_s = TX_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    bit_s   = bit_r + 4'd1;
                    txd_s   = shift_r[0];
                    shift_s = {1'b1, shift_r[8:1]};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = TX_IDLE;
                txd_s   = 1'b1;
            end
        endcase
    end

    // Transmitter state register; the line idles high out of reset.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_r <= TX_IDLE;
            cnt_r   <= '0;
            bit_r   <= 4'd0;
            shift_r <= 9'h1FF;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            txd_r   <= txd_s;
        end
    end

    assign ready = (state_r == TX_IDLE);
    assign txd   = txd_r;

endmodule

// File: rtl/res_dump_uart.sv
// Debug monitor: walks the CPU resource port and streams "AA:DD " entries
// followed by CR LF over UART.
module res_dump_uart
    import res_dump_uart_pkg::*;
#(
    parameter int NUM_RES  = 16,
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       start,
    output logic [7:0] resad,
    input  logic [7:0] resdt,
    output logic       txd,
    output logic       busy
);

    localparam logic [8:0] ADDR_LAST = 9'(NUM_RES - 1);

    dump_state_t state_r, state_s;
    logic [8:0]  addr_r, addr_s;
    logic [7:0]  resad_r, resad_s;
    logic [7:0]  data_r, data_s;
    logic [2:0]  idx_r, idx_s;
    logic        busy_r, busy_s;
    logic        tx_valid_s, tx_ready_s;
    logic [7:0]  tx_data_s, entry_char_s;

    // Character of the current entry selected by the char index.
    always_comb begin
        case (idx_r)
            3'd0:    entry_char_s = hex_char(addr_r[7:4]);
            3'd1:    entry_char_s = hex_char(addr_r[3:0]);
            3'd2:    entry_char_s = ASCII_COLON;
            3'd3:    entry_char_s = hex_char(data_r[7:4]);
            3'd4:    entry_char_s = hex_char(data_r[3:0]);
            default: entry_char_s = ASCII_SPACE;
        endcase
    end

    // Dump sequencer; index 6 in SEND and 2 in EOL wait for the last frame to drain.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        resad_s    = resad_r;
        data_s     = data_r;
        idx_s      = idx_r;
        busy_s     = busy_r;
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_SETADR;
                    addr_s  = 9'd0;
                    busy_s  = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_SETADR: begin
                resad_s = addr_r[7:0];
                state_s = S_WAIT;
            end
            S_WAIT: begin
                state_s = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Address-high nibble needs no data, so it goes out while data is latched.
                data_s     = resdt;
                tx_valid_s = 1'b1;
                tx_data_s  = hex_char(addr_r[7:4]);
                state_s    = S_SEND;
                if (tx_ready_s) begin
                    idx_s = 3'd1;
                end else begin
                    idx_s = 3'd0;
                end
            end
            S_SEND: begin
                if (idx_r == 3'd6) begin
                    if (tx_ready_s) begin
                        addr_s  = addr_r + 9'd1;
                        state_s = S_SETADR;
                    end else begin
                        state_s = S_SEND;
                    end
                end else begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = entry_char_s;
                    if (tx_ready_s && idx_r == 3'd5) begin
                        if (addr_r == ADDR_LAST) begin
                            state_s = S_EOL;
                            idx_s   = 3'd0;
                        end else begin
                            idx_s = 3'd6;
                        end
                    end else if (tx_ready_s) begin
                        idx_s = idx_r + 3'd1;
                    end else begin
                        idx_s = idx_r;
                    end
                end
            end
            S_EOL: begin
                if (idx_r == 3'd2) begin
                    if (tx_ready_s) begin
                        state_s = S_IDLE;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = S_EOL;
                    end
                end else begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = (idx_r == 3'd0) ? ASCII_CR : ASCII_LF;
                    if (tx_ready_s) begin
                        idx_s = idx_r + 3'd1;
                    end else begin
                        idx_s = idx_r;
                    end
                end
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Sequencer, address, data and output registers.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_r <= S_IDLE;
            addr_r  <= 9'd0;
            resad_r <= 8'd0;
            data_r  <= 8'd0;
            idx_r   <= 3'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            resad_r <= resad_s;
            data_r  <= data_s;
            idx_r   <= idx_s;
            busy_r  <= busy_s;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clock   (clock),
        .reset_N (reset_N),
        .valid   (tx_valid_s),
        .data    (tx_data_s),
        .ready   (tx_ready_s),
        .txd     (txd)
    );

    assign resad = resad_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_res_dump_uart.sv
// Bench for res_dump_uart: UART decoder feeding a per-DUT expected-character
// scoreboard, plus dump-length and reset-response checks.
module tb_res_dump_uart;

    localparam int NA = 2;
    localparam int BA = 4;
    localparam int NB = 256;
    localparam int BB = 2;
    localparam int LIMIT = 60000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_N;
    logic       start_a, start_b;
    logic [7:0] resad_a, resad_b, resdt_a, resdt_b;
    logic       txd_a, txd_b, busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    int         mode;
    logic [7:0] manual;
    logic [7:0] man_final;
    logic [7:0] tbl [2];

    bit         rx_act [2];
    int         rx_t   [2];
    logic [7:0] rx_sh  [2];
    int         rx_cnt [2];
    logic       mon_line;
    logic [7:0] mon_e;
    int         mon_j, mon_bd, mon_half;

    res_dump_uart #(.NUM_RES(NA), .BAUD_DIV(BA)) dut_a (
        .clock(clock), .reset_N(reset_N), .start(start_a),
        .resad(resad_a), .resdt(resdt_a), .txd(txd_a), .busy(busy_a)
    );

    res_dump_uart #(.NUM_RES(NB), .BAUD_DIV(BB)) dut_b (
        .clock(clock), .reset_N(reset_N), .start(start_b),
        .resad(resad_b), .resdt(resdt_b), .txd(txd_b), .busy(busy_b)
    );

    always_comb begin
        case (mode)
            0:       resdt_a = resad_a ^ 8'hA5;
            1:       resdt_a = manual;
            default: resdt_a = tbl[resad_a[0]];
        endcase
    end
    assign resdt_b = resad_b;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'd0, n};
        else           return 8'h41 + ({4'd0, n} - 8'd10);
    endfunction

    task automatic push_c(input int u, input logic [7:0] c);
        if (u == 0) q_a.push_back(c);
        else        q_b.push_back(c);
    endtask

    task automatic push_dump(input int u, input int n);
        logic [7:0] a, d;
        for (int i = 0; i < n; i++) begin
            a = 8'(i);
            if (u == 1)         d = a;
            else if (mode == 0) d = a ^ 8'hA5;
            else if (mode == 1) d = man_final;
            else                d = tbl[i];
            push_c(u, hexc(a[7:4])); push_c(u, hexc(a[3:0])); push_c(u, 8'h3A);
            push_c(u, hexc(d[7:4])); push_c(u, hexc(d[3:0])); push_c(u, 8'h20);
        end
        push_c(u, 8'h0D);
        push_c(u, 8'h0A);
    endtask

    // Leaves the bench #1 after the edge at which start is sampled.
    task automatic pulse_start(input int u);
        @(posedge clock); #1;
        if (u == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int u, input int n0, input int exp, input string tag);
        int n;
        n = n0;
        while (((u == 0) ? busy_a : busy_b) && n < LIMIT) begin
            @(posedge clock); #1;
            n++;
        end
        chk_eq(tag, n, exp);
    endtask

    // UART decoder: samples mid-bit on the falling edge, compares against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            for (int u = 0; u < 2; u++) begin
                mon_line = (u == 0) ? txd_a : txd_b;
                mon_bd   = (u == 0) ? BA : BB;
                mon_half = mon_bd / 2;
                if (!reset_N) begin
                    rx_act[u] = 1'b0;
                end else if (!rx_act[u]) begin
                    if (!mon_line) begin
                        rx_act[u] = 1'b1;
                        rx_t[u]   = 0;
                    end
                end else begin
                    rx_t[u]++;
                    if (rx_t[u] == mon_half) begin
                        chk_eq("start_bit", mon_line, 1'b0);
                        if (mon_line) rx_act[u] = 1'b0;
                    end else if (rx_t[u] > mon_half && ((rx_t[u] - mon_half) % mon_bd) == 0) begin
                        mon_j = (rx_t[u] - mon_half) / mon_bd;
                        if (mon_j <= 8) begin
                            rx_sh[u][mon_j-1] = mon_line;
                        end else begin
                            chk_eq("stop_bit", mon_line, 1'b1);
                            rx_act[u] = 1'b0;
                            rx_cnt[u]++;
                            if (u == 0) begin
                                chk_eq("rx_a_expected", q_a.size() > 0, 1'b1);
                                if (q_a.size() > 0) begin
                                    mon_e = q_a.pop_front();
                                    chk_eq("rx_a_char", rx_sh[0], mon_e);
                                end
                            end else begin
                                chk_eq("rx_b_expected", q_b.size() > 0, 1'b1);
                                if (q_b.size() > 0) begin
                                    mon_e = q_b.pop_front();
                                    chk_eq("rx_b_char", rx_sh[1], mon_e);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int dump_a;
        int dump_b;
        dump_a = 3 * NA + 10 * BA * (6 * NA + 2);
        dump_b = 3 * NB + 10 * BB * (6 * NB + 2);
        reset_N = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode = 0;
        manual = 8'h00;
        man_final = 8'h22;
        tbl[0] = 8'h09;
        tbl[1] = 8'h0A;
        for (int u = 0; u < 2; u++) begin
            rx_act[u] = 1'b0; rx_t[u] = 0; rx_cnt[u] = 0; rx_sh[u] = 8'h00;
        end
        repeat (3) @(posedge clock);
        #1;
        chk_eq("rst_resad", resad_a, 8'h00);
        chk_eq("rst_txd", txd_a, 1'b1);
        chk_eq("rst_busy", busy_a, 1'b0);
        reset_N = 1'b1;

        // Basic dump with resdt = resad ^ A5
        base = rx_cnt[0];
        push_dump(0, NA);
        pulse_start(0);
        @(posedge clock); #1;
        chk_eq("busy_rise", busy_a, 1'b1);
        chk_eq("resad_first", resad_a, 8'h00);
        wait_done(0, 1, dump_a, "dump_cycles");
        chk_eq("dump_chars", rx_cnt[0] - base, 6 * NA + 2);
        chk_eq("dump_drained", q_a.size(), 0);

        // Capture edge: resdt changes after the WAIT cycle begins
        mode = 1;
        manual = 8'h11;
        base = rx_cnt[0];
        push_dump(0, NA);
        pulse_start(0);
        @(posedge clock); #1;
        chk_eq("resad_k1", resad_a, 8'h00);
        @(posedge clock); #1;
        manual = 8'h22;
        wait_done(0, 2, dump_a, "sample_cycles");
        chk_eq("sample_drained", q_a.size(), 0);

        // Second start mid-dump must be ignored
        mode = 0;
        base = rx_cnt[0];
        push_dump(0, NA);
        pulse_start(0);
        repeat (10) begin @(posedge clock); #1; end
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        wait_done(0, 11, dump_a, "restart_cycles");
        repeat (60) @(posedge clock);
        #1;
        chk_eq("restart_idle", busy_a, 1'b0);
        chk_eq("restart_chars", rx_cnt[0] - base, 6 * NA + 2);
        chk_eq("restart_drained", q_a.size(), 0);

        // Reset during the third character
        base = rx_cnt[0];
        push_dump(0, NA);
        pulse_start(0);
        repeat (92) begin @(posedge clock); #1; end
        reset_N = 1'b0;
        #1;
        chk_eq("rst_mid_txd", txd_a, 1'b1);
        chk_eq("rst_mid_busy", busy_a, 1'b0);
        chk_eq("rst_mid_chars", rx_cnt[0] - base, 2);
        q_a.delete();
        @(posedge clock); #1;
        chk_eq("rst_mid_resad", resad_a, 8'h00);
        reset_N = 1'b1;
        base = rx_cnt[0];
        push_dump(0, NA);
        pulse_start(0);
        wait_done(0, 0, dump_a, "post_rst_cycles");
        chk_eq("post_rst_chars", rx_cnt[0] - base, 6 * NA + 2);
        chk_eq("post_rst_drained", q_a.size(), 0);

        // Hex boundaries 09 / 0A, then F0 / 5B
        mode = 2;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                tbl[0] = 8'hF0;
                tbl[1] = 8'h5B;
            end
            push_dump(0, NA);
            pulse_start(0);
            wait_done(0, 0, dump_a, "hex_cycles");
            chk_eq("hex_drained", q_a.size(), 0);
        end

        // Full 256-entry dump, no address wrap
        base = rx_cnt[1];
        push_dump(1, NB);
        pulse_start(1);
        wait_done(1, 0, dump_b, "full_cycles");
        chk_eq("full_chars", rx_cnt[1] - base, 6 * NB + 2);
        chk_eq("full_drained", q_b.size(), 0);
        chk_eq("full_last_resad", resad_b, 8'hFF);
        repeat (20) @(posedge clock);
        #1;
        chk_eq("full_idle", busy_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
